alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the datapath's combinational ALU. It keeps the same 3-bit operation encoding and adds a `WIDTH` parameter, valid/ready flow control on both sides, and a registered single-entry result. Multiplication is iterative shift-add, one bit per cycle. It also produces zero, carry and overflow flags, and accepts a synchronous flush. It sits between the register-read stage and writeback, so the datapath can stall on back-pressure and on multi-cycle multiplies.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 2.
- `CNT_W`, default `$clog2(WIDTH+1)`: multiply step-counter width; derived, not overridden.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous abort; discards the in-flight multiply and the held result.
- `in_valid` input 1: `sel`/`op1`/`op2` are valid.
- `in_ready` output 1: block accepts an operation this cycle.
- `sel` input 3: operation code.
- `op1` input `WIDTH`: first operand.
- `op2` input `WIDTH`: second operand.
- `out_valid` output 1: `Result` and flags are valid.
- `out_ready` input 1: consumer takes the result this cycle.
- `Result` output `WIDTH`: registered result.
- `zflag` output 1: `Result == 0`.
- `cflag` output 1: carry / no-borrow / multiply-overflow, as defined below.
- `vflag` output 1: signed overflow for ADD/SUB; 0 for all other operations.
- `busy` output 1: multiply in progress.

## Operation
- Operation codes and results (all results truncated to `WIDTH`):
  - 000 OR: `op1|op2`.
  - 001 ADD: `op1+op2`.
  - 010 MUL: low `WIDTH` bits of `op1*op2`, unsigned.
  - 011 XOR: `op1^op2`.
  - 100 SUB: `op1-op2`.
  - 101 SLT: unsigned less-than; `Result` is 1 if `op1<op2`, else 0.
  - 110 SHL1: `op2<<1`.
  - 111 AND: `op1&op2`.
- Flags:
  - ADD: `cflag` is the carry-out of bit `WIDTH-1`.
  - SUB: `cflag` is the carry-out of `op1 + ~op2 + 1`, i.e. 1 when `op1 ≥ op2` unsigned.
  - MUL: `cflag` is 1 when any of the upper `WIDTH` product bits is nonzero.
  - All other operations: `cflag = 0`.
  - `vflag` follows two's-complement rules for ADD/SUB and is 0 otherwise.
- Transfers: an input transfer occurs when `in_valid & in_ready`; an output transfer occurs when `out_valid & out_ready`.
- `in_ready = rst_n & (state==IDLE) & (!out_valid | out_ready) & !flush`. Pass-through is allowed: a new operation may be accepted in the same cycle the held result is drained.
- FSM states:
  - IDLE:
    - Non-MUL op accepted: compute the result, load `Result` and flags, set `out_valid`, stay in IDLE.
    - MUL op accepted: load the multiplicand (`op1`, zero-extended to `2*WIDTH`), the multiplier (`op2`) and a `2*WIDTH` accumulator of 0; set the counter to `WIDTH`; go to MUL.
  - MUL:
    - Each cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator; shift the multiplicand left 1 and the multiplier right 1; decrement the counter.
    - When the counter reaches 0 on this edge: write `Result` from the accumulator low half and `cflag` from the accumulator high half being nonzero; set `out_valid`; go to IDLE.
    - `busy = 1` throughout MUL.
- Holding: `out_valid` stays set, and `Result`/flags stay stable, until an output transfer occurs. Inputs are ignored while `in_ready = 0`.
- `flush`: at the next edge, `out_valid` goes to 0 and the FSM goes to IDLE with the counter cleared. `Result` and flags keep their values but are not valid. `flush` has priority over every other event.
- Reset (asynchronous assert, any state, including mid-multiply):
  - State IDLE, counter 0.
  - `out_valid = 0`, `Result = 0`, `zflag = 0`, `cflag = 0`, `vflag = 0`, `busy = 0`.
  - `in_ready = 0` while `rst_n` is low.
- `zflag` is registered together with `Result`. Its reset value is 0, even though `Result` is 0.

## Timing
- Non-MUL ops: accepted at edge k; `out_valid` and the result are visible after edge k. Latency 1 cycle; throughput 1 per cycle when `out_ready` is held high.
- MUL: accepted at edge k; `busy` is high after edge k. The step edges are k+1 through k+`WIDTH`. `out_valid` is visible after edge k+`WIDTH`, and `busy` drops at the same edge. Latency `WIDTH` cycles.
- The next operation can be accepted in the cycle `out_valid` is first high, provided `out_ready = 1`.
- With `out_ready = 0` and `out_valid = 1`, `in_ready` is 0 and the block stalls indefinitely with no state change.
- `flush` in the same cycle as `in_valid`: no acceptance, since `in_ready` is 0.
- Reset deassertion: `in_ready` rises in the same cycle, because it is combinational on `rst_n` and state.

## Test plan
- Reset mid-multiply: `rst_n` pulsed low during cycle 5 of MUL → all outputs 0 immediately; `in_ready = 1` after release; the next ADD 2+3 returns 5 at latency 1.
- Back-to-back ops with `out_ready = 1`: ADD `FFFFFFFF+1`, SUB `5-7`, SLT `3<9`, SHL1 of `op2 = 80000001`, one per cycle → results in order:
  - 0 (`zflag = 1`, `cflag = 1`).
  - `FFFFFFFE` (`cflag = 0`).
  - 1.
  - 2.
- MUL 7*6 accepted at edge k → `busy` high for 32 cycles; `Result = 42` visible after edge k+32; `cflag = 0`. MUL `FFFFFFFF*2` → `FFFFFFFE`, `cflag = 1`.
- Back-pressure: `out_ready = 0` for 10 cycles after an XOR `F0F0F0F0^FFFFFFFF` → `Result = 0F0F0F0F` held stable; `in_ready = 0` throughout; releasing `out_ready` with `in_valid` high accepts the next op in that same cycle.
- Signed overflow: ADD `7FFFFFFF+1` → `vflag = 1`; SUB `80000000-1` → `vflag = 1`, `cflag = 1`; OR and AND → `vflag = 0`, `cflag = 0`.
- Flush during MUL at cycle 10 → `out_valid` never rises for that op; `busy = 0` after the flush edge; the next AND `C & A` = 8 completes at latency 1. Repeat all scenarios at `WIDTH = 8`, checking the MUL latency of 8.

Source files
------------

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle for alu_seq.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       sel;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             zflag;
    logic             cflag;
    logic             vflag;
    logic             busy;

    // Producer/consumer side (register-read stage and writeback).
    modport master (
        output flush, in_valid, sel, op1, op2, out_ready,
        input  in_ready, out_valid, Result, zflag, cflag, vflag, busy
    );

    // ALU side.
    modport slave (
        input  flush, in_valid, sel, op1, op2, out_ready,
        output in_ready, out_valid, Result, zflag, cflag, vflag, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with a registered single-entry result and iterative shift-add multiply.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic       clk,
    input logic       rst_n,
    alu_seq_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned W1    = WIDTH + 1;
    localparam int unsigned W2    = 2 * WIDTH;

    typedef enum logic [2:0] {
        OP_OR   = 3'b000,
        OP_ADD  = 3'b001,
        OP_MUL  = 3'b010,
        OP_XOR  = 3'b011,
        OP_SUB  = 3'b100,
        OP_SLT  = 3'b101,
        OP_SHL1 = 3'b110,
        OP_AND  = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [W2-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [W2-1:0]    acc;
    logic [WIDTH-1:0] result;
    logic             zflag;
    logic             cflag;
    logic             vflag;
    logic             out_valid;
    logic             busy;

    logic             in_ready;
    logic             accept;
    op_e              op;
    logic [W1-1:0]    add_sum;
    logic [W1-1:0]    sub_sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [W2-1:0]    acc_step;

    // Accept only when idle with the output slot free (or draining this cycle).
    assign in_ready = rst_n & (state == S_IDLE) & (~out_valid | bus.out_ready) & ~bus.flush;
    assign accept   = bus.in_valid & in_ready;
    assign op       = op_e'(bus.sel);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.Result    = result;
    assign bus.zflag     = zflag;
    assign bus.cflag     = cflag;
    assign bus.vflag     = vflag;
    assign bus.busy      = busy;

    // Single-cycle result and flags for every non-multiply operation.
    always_comb begin
        add_sum = {1'b0, bus.op1} + {1'b0, bus.op2};
        sub_sum = {1'b0, bus.op1} + {1'b0, ~bus.op2} + W1'(1);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_OR:   alu_res = bus.op1 | bus.op2;
            OP_ADD: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != bus.op1[WIDTH-1]);
            end
            OP_XOR:  alu_res = bus.op1 ^ bus.op2;
            OP_SUB: begin
                alu_res = sub_sum[WIDTH-1:0];
                alu_c   = sub_sum[WIDTH];
                alu_v   = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) &&
                          (sub_sum[WIDTH-1] != bus.op1[WIDTH-1]);
            end
            OP_SLT:  alu_res = WIDTH'(bus.op1 < bus.op2);
            OP_SHL1: alu_res = {bus.op2[WIDTH-2:0], 1'b0};
            OP_AND:  alu_res = bus.op1 & bus.op2;
            default: alu_res = '0;
        endcase
    end

    // One shift-add partial-product step.
    always_comb begin
        acc_step = acc;
        if (mplier[0]) begin
            acc_step = acc + mcand;
        end
    end

    // Control FSM, multiply datapath and held result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            result    <= '0;
            zflag     <= 1'b0;
            cflag     <= 1'b0;
            vflag     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (bus.flush) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (out_valid && bus.out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            mcand  <= W2'(bus.op1);
                            mplier <= bus.op2;
                            acc    <= '0;
                            cnt    <= CNT_W'(WIDTH);
                            busy   <= 1'b1;
                            state  <= S_MUL;
                        end else begin
                            result    <= alu_res;
                            zflag     <= (alu_res == '0);
                            cflag     <= alu_c;
                            vflag     <= alu_v;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_step;
                    mcand  <= {mcand[W2-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result    <= acc_step[WIDTH-1:0];
                        zflag     <= (acc_step[WIDTH-1:0] == '0);
                        cflag     <= (acc_step[W2-1:WIDTH] != '0);
                        vflag     <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: two instances (WIDTH 32 and 8) sharing clock and reset.
module tb_alu_seq;
    localparam logic [2:0] OR_ = 3'd0, ADD = 3'd1, MUL = 3'd2, XOR_ = 3'd3;
    localparam logic [2:0] SUB = 3'd4, SLT = 3'd5, SHL = 3'd6, AND_ = 3'd7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) b32();
    alu_seq_if #(.WIDTH(8))  b8();

    alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[15];
    int total = 0;
    int bad   = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic set_in(int w, logic v, logic [2:0] s, logic [31:0] a, logic [31:0] b);
        if (w == 8) begin
            b8.in_valid = v; b8.sel = s; b8.op1 = a[7:0]; b8.op2 = b[7:0];
        end else begin
            b32.in_valid = v; b32.sel = s; b32.op1 = a; b32.op2 = b;
        end
    endtask

    task automatic set_ctl(int w, logic ordy, logic fl);
        if (w == 8) begin b8.out_ready = ordy; b8.flush = fl; end
        else begin b32.out_ready = ordy; b32.flush = fl; end
    endtask

    function automatic logic [31:0] g_res(int w);
        return (w == 8) ? 32'(b8.Result) : b32.Result;
    endfunction
    function automatic logic g_ov(int w);
        return (w == 8) ? b8.out_valid : b32.out_valid;
    endfunction
    function automatic logic g_rdy(int w);
        return (w == 8) ? b8.in_ready : b32.in_ready;
    endfunction
    function automatic logic g_busy(int w);
        return (w == 8) ? b8.busy : b32.busy;
    endfunction
    function automatic logic [31:0] g_flags(int w);
        return (w == 8) ? {29'd0, b8.zflag, b8.cflag, b8.vflag}
                        : {29'd0, b32.zflag, b32.cflag, b32.vflag};
    endfunction

    // Reference: plain integer arithmetic on masked operands, signed range test for overflow.
    function automatic void model(int w, logic [2:0] s, logic [31:0] a_in, logic [31:0] b_in,
                                  output logic [31:0] r, output logic c, output logic v);
        longint unsigned mask, a, b, full;
        longint sa, sb, sr, lim;
        mask = (64'd1 << w) - 64'd1;
        a = 64'(a_in) & mask;
        b = 64'(b_in) & mask;
        lim = longint'(64'd1 << (w - 1));
        sa = (((a >> (w - 1)) & 64'd1) != 0) ? longint'(a) - longint'(mask) - 1 : longint'(a);
        sb = (((b >> (w - 1)) & 64'd1) != 0) ? longint'(b) - longint'(mask) - 1 : longint'(b);
        c = 1'b0; v = 1'b0; sr = 0; full = 0;
        case (s)
            OR_:  full = a | b;
            ADD:  begin full = a + b; c = ((full >> w) != 0); sr = sa + sb;
                        v = (sr >= lim) || (sr < -lim); end
            MUL:  begin full = a * b; c = ((full >> w) != 0); end
            XOR_: full = a ^ b;
            SUB:  begin full = a - b; c = (a >= b); sr = sa - sb;
                        v = (sr >= lim) || (sr < -lim); end
            SLT:  full = (a < b) ? 64'd1 : 64'd0;
            SHL:  full = b << 1;
            default: full = a & b;
        endcase
        r = 32'(full & mask);
    endfunction

    // Issue one op with out_ready high, wait (bounded) for the result, check it, then drain.
    task automatic do_op_x(int w, logic [2:0] s, logic [31:0] a, logic [31:0] b,
                           logic [31:0] er, logic ez, logic ec, logic ev, string nm);
        int n = 0;
        int bc = 0;
        set_ctl(w, 1'b1, 1'b0);
        set_in(w, 1'b1, s, a, b);
        #1;
        chk({nm, ".in_ready"}, 32'(g_rdy(w)), 32'd1);
        @(posedge clk); #1;
        set_in(w, 1'b0, 3'd0, 32'd0, 32'd0);
        while (!g_ov(w) && n < 300) begin
            if (g_busy(w)) bc++;
            @(posedge clk); #1;
            n++;
        end
        chk({nm, ".latency"}, 32'(n), (s == MUL) ? 32'(w) : 32'd0);
        chk({nm, ".busy_cycles"}, 32'(bc), (s == MUL) ? 32'(w) : 32'd0);
        chk({nm, ".result"}, g_res(w), er);
        chk({nm, ".zcv"}, g_flags(w), {29'd0, ez, ec, ev});
        chk({nm, ".busy_end"}, 32'(g_busy(w)), 32'd0);
        @(posedge clk); #1;
        chk({nm, ".drained"}, 32'(g_ov(w)), 32'd0);
    endtask

    task automatic do_op(int w, logic [2:0] s, logic [31:0] a, logic [31:0] b, string nm);
        logic [31:0] er;
        logic ec, ev;
        model(w, s, a, b, er, ec, ev);
        do_op_x(w, s, a, b, er, (er == 32'd0), ec, ev, nm);
    endtask

    // Four non-multiply ops on consecutive cycles.
    task automatic back_to_back();
        set_ctl(32, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            set_in(32, 1'b1, vecs[i].sel, vecs[i].a, vecs[i].b);
            #1;
            chk($sformatf("b2b%0d.in_ready", i), 32'(g_rdy(32)), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("b2b%0d.valid", i), 32'(g_ov(32)), 32'd1);
            chk($sformatf("b2b%0d.result", i), g_res(32), vecs[i].r);
            chk($sformatf("b2b%0d.zcv", i), g_flags(32), {29'd0, vecs[i].z, vecs[i].c, vecs[i].v});
        end
        set_in(32, 1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        chk("b2b.drained", 32'(g_ov(32)), 32'd0);
    endtask

    // Hold a result under back-pressure, then release with a new op in the same cycle.
    task automatic sc_backpressure(int w);
        logic [31:0] er;
        logic ec, ev;
        logic stable = 1'b1;
        logic stalled = 1'b1;
        model(w, XOR_, 32'hF0F0F0F0, 32'hFFFFFFFF, er, ec, ev);
        set_ctl(w, 1'b0, 1'b0);
        set_in(w, 1'b1, XOR_, 32'hF0F0F0F0, 32'hFFFFFFFF);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            if (!g_ov(w) || g_res(w) !== er) stable = 1'b0;
            if (g_rdy(w)) stalled = 1'b0;
            @(posedge clk); #1;
        end
        chk($sformatf("bp%0d.held", w), 32'(stable), 32'd1);
        chk($sformatf("bp%0d.stalled", w), 32'(stalled), 32'd1);
        chk($sformatf("bp%0d.result", w), g_res(w), er);
        set_in(w, 1'b1, AND_, 32'hC, 32'hA);
        set_ctl(w, 1'b1, 1'b0);
        #1;
        chk($sformatf("bp%0d.release_rdy", w), 32'(g_rdy(w)), 32'd1);
        @(posedge clk); #1;
        set_in(w, 1'b0, 3'd0, 32'd0, 32'd0);
        chk($sformatf("bp%0d.next_valid", w), 32'(g_ov(w)), 32'd1);
        chk($sformatf("bp%0d.next_result", w), g_res(w), 32'd8);
        @(posedge clk); #1;
    endtask

    // Flush part-way through a multiply, with a competing in_valid on the flush cycle.
    task automatic sc_flush(int w);
        int fc = (w == 32) ? 10 : 5;
        logic saw = 1'b0;
        set_ctl(w, 1'b1, 1'b0);
        set_in(w, 1'b1, MUL, 32'd7, 32'd6);
        @(posedge clk); #1;
        set_in(w, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (fc - 1) @(posedge clk);
        #1;
        chk($sformatf("fl%0d.busy_before", w), 32'(g_busy(w)), 32'd1);
        set_ctl(w, 1'b1, 1'b1);
        set_in(w, 1'b1, OR_, 32'h3, 32'h4);
        #1;
        chk($sformatf("fl%0d.rdy_during", w), 32'(g_rdy(w)), 32'd0);
        @(posedge clk); #1;
        set_ctl(w, 1'b1, 1'b0);
        set_in(w, 1'b0, 3'd0, 32'd0, 32'd0);
        chk($sformatf("fl%0d.busy_after", w), 32'(g_busy(w)), 32'd0);
        for (int i = 0; i < w + 4; i++) begin
            if (g_ov(w)) saw = 1'b1;
            @(posedge clk); #1;
        end
        chk($sformatf("fl%0d.no_valid", w), 32'(saw), 32'd0);
        do_op(w, AND_, 32'hC, 32'hA, $sformatf("fl%0d.and", w));
    endtask

    // Asynchronous reset in cycle 5 of a multiply.
    task automatic sc_reset(int w);
        do_op(w, ADD, 32'hFFFFFFFF, 32'd2, $sformatf("rs%0d.pre", w));
        set_in(w, 1'b1, MUL, 32'h1234, 32'h55);
        @(posedge clk); #1;
        set_in(w, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk($sformatf("rs%0d.valid", w), 32'(g_ov(w)), 32'd0);
        chk($sformatf("rs%0d.result", w), g_res(w), 32'd0);
        chk($sformatf("rs%0d.zcv", w), g_flags(w), 32'd0);
        chk($sformatf("rs%0d.busy", w), 32'(g_busy(w)), 32'd0);
        chk($sformatf("rs%0d.rdy_low", w), 32'(g_rdy(w)), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        chk($sformatf("rs%0d.rdy_high", w), 32'(g_rdy(w)), 32'd1);
        do_op(w, ADD, 32'd2, 32'd3, $sformatf("rs%0d.add", w));
    endtask

    task automatic random_ops(int w, int cnt);
        logic [2:0] s;
        logic [31:0] a, b;
        for (int i = 0; i < cnt; i++) begin
            s = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'hFFFFFFFF;
                1: b = 32'h80000000 >> (32 - w);
                2: b = 32'd0;
                default: ;
            endcase
            do_op(w, s, a, b, $sformatf("rnd%0d_%0d_op%0d", w, i, s));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{SLT,  32'h00000003, 32'h00000009, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{SHL,  32'h00001234, 32'h80000001, 32'h00000002, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{XOR_, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{OR_,  32'h0000F0F0, 32'h0F0F0000, 32'h0F0FF0F0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{AND_, 32'h0000000C, 32'h0000000A, 32'h00000008, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{MUL,  32'h00000007, 32'h00000006, 32'h0000002A, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{MUL,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{SLT,  32'h00000009, 32'h00000003, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{SUB,  32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{AND_, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{MUL,  32'h00000000, 32'h00012345, 32'h00000000, 1'b1, 1'b0, 1'b0};

        set_in(32, 1'b0, 3'd0, 32'd0, 32'd0);
        set_in(8, 1'b0, 3'd0, 32'd0, 32'd0);
        set_ctl(32, 1'b1, 1'b0);
        set_ctl(8, 1'b1, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int w = 8; w <= 32; w += 24) begin
            chk($sformatf("reset%0d.valid", w), 32'(g_ov(w)), 32'd0);
            chk($sformatf("reset%0d.result", w), g_res(w), 32'd0);
            chk($sformatf("reset%0d.zcv", w), g_flags(w), 32'd0);
            chk($sformatf("reset%0d.busy", w), 32'(g_busy(w)), 32'd0);
            chk($sformatf("reset%0d.rdy", w), 32'(g_rdy(w)), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("reset.rdy_release", 32'(g_rdy(32)), 32'd1);

        back_to_back();
        for (int i = 0; i < 15; i++)
            do_op_x(32, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].r,
                    vecs[i].z, vecs[i].c, vecs[i].v, $sformatf("vec32_%0d", i));
        for (int i = 0; i < 15; i++)
            do_op(8, vecs[i].sel, vecs[i].a, vecs[i].b, $sformatf("vec8_%0d", i));

        sc_backpressure(32);
        sc_backpressure(8);
        sc_flush(32);
        sc_flush(8);
        sc_reset(32);
        sc_reset(8);
        random_ops(32, 40);
        random_ops(8, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
